// File: rtl/sn_window_counter_pkg.sv
// Shared definitions for the stochastic window counter: FSM state encoding,
// default sizes and the width helpers used to derive CNT_W and SUM_W.
package sn_window_counter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    localparam int DEF_LANES   = 4;
    localparam int DEF_WIN_LEN = 16;

    // Width that holds every value 0..win_len inclusive.
    function automatic int cnt_width(input int win_len);
        return $clog2(win_len + 1);
    endfunction

    function automatic int sum_width(input int win_len, input int lanes);
        return cnt_width(win_len) + $clog2(lanes);
    endfunction

endpackage

// File: rtl/sn_lane_counter.sv
// One stochastic lane: product gate (AND, or XNOR when
// SN_WINDOW_COUNTER_BIPOLAR_EN is defined) feeding a ones accumulator.
module sn_lane_counter
    import sn_window_counter_pkg::*;
#(
    parameter int CNT_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_sn_bit,
    input  logic             i_w_bit,
    input  logic             i_load,
    input  logic             i_inc,
    input  logic             i_clear,
    output logic             o_prod,
    output logic [CNT_W-1:0] o_cnt
);

    logic             w_prod;
    logic [CNT_W-1:0] r_cnt;

`ifdef SN_WINDOW_COUNTER_BIPOLAR_EN
    assign w_prod = ~(i_sn_bit ^ i_w_bit);
`else
    assign w_prod = i_sn_bit & i_w_bit;
`endif

    // Clear wins so a closing window always leaves the lane empty for the next one.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(w_prod);
        end else if (i_inc) begin
            r_cnt <= r_cnt + CNT_W'(w_prod);
        end
    end

    assign o_prod = w_prod;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/sn_window_counter.sv
// Counts stochastic products per lane over one generation window and presents
// lane counts, reduced sum and window length on a valid/ready output register.
// Bipolar (XNOR, signed sum) mode is enabled by SN_WINDOW_COUNTER_BIPOLAR_EN.
module sn_window_counter
    import sn_window_counter_pkg::*;
#(
    parameter  int LANES   = DEF_LANES,
    parameter  int WIN_LEN = DEF_WIN_LEN,
    localparam int CNT_W   = cnt_width(WIN_LEN),
    localparam int SUM_W   = sum_width(WIN_LEN, LANES),
`ifdef SN_WINDOW_COUNTER_BIPOLAR_EN
    localparam int OUT_W   = SUM_W + 1
`else
    localparam int OUT_W   = SUM_W
`endif
) (
    input  logic             i_clk_sn_acc,
    input  logic             i_rst_n_sn_acc,
    input  logic             i_isgen,
    input  logic             i_sn_bit [LANES],
    input  logic             i_w_bit  [LANES],
    output logic [CNT_W-1:0] o_lane_cnt [LANES],
`ifdef SN_WINDOW_COUNTER_BIPOLAR_EN
    output logic signed [OUT_W-1:0] o_sum,
`else
    output logic [OUT_W-1:0] o_sum,
`endif
    output logic [CNT_W-1:0] o_win_len,
    output logic             o_valid,
    input  logic             i_ready,
    output logic             o_overrun
);

    state_t           r_state;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_lane_cnt [LANES];
    logic [OUT_W-1:0] r_sum;
    logic [CNT_W-1:0] r_win_len;
    logic             r_valid;
    logic             r_overrun;

    logic [CNT_W-1:0] w_acc       [LANES];
    logic             w_prod      [LANES];
    logic [CNT_W-1:0] w_close_cnt [LANES];
    logic [SUM_W-1:0] w_part      [LANES+1];
    logic             w_cap;
    logic             w_close;
    logic             w_load;
    logic             w_inc;
    logic             w_free;
    logic [CNT_W-1:0] w_close_len;
    logic [OUT_W-1:0] w_sum_res;

    // The cap cycle closes with its own bit folded in, so the result is
    // taken from acc + p rather than the not-yet-updated accumulator.
    assign w_cap       = (r_state == ACC) && i_isgen && (r_len == CNT_W'(WIN_LEN - 1));
    assign w_close     = (r_state == ACC) && (!i_isgen || w_cap);
    assign w_load      = (r_state == IDLE) && i_isgen;
    assign w_inc       = (r_state == ACC) && i_isgen && !w_cap;
    assign w_close_len = w_cap ? (r_len + CNT_W'(1)) : r_len;
    assign w_free      = !r_valid || i_ready;

    assign w_part[0] = '0;

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        sn_lane_counter #(
            .CNT_W (CNT_W)
        ) u_lane (
            .i_clk    (i_clk_sn_acc),
            .i_rst_n  (i_rst_n_sn_acc),
            .i_sn_bit (i_sn_bit[gi]),
            .i_w_bit  (i_w_bit[gi]),
            .i_load   (w_load),
            .i_inc    (w_inc),
            .i_clear  (w_close),
            .o_prod   (w_prod[gi]),
            .o_cnt    (w_acc[gi])
        );

        assign w_close_cnt[gi] = w_acc[gi] + ((w_cap && w_prod[gi]) ? CNT_W'(1) : CNT_W'(0));
        assign w_part[gi+1]    = w_part[gi] + SUM_W'(w_close_cnt[gi]);
    end

`ifdef SN_WINDOW_COUNTER_BIPOLAR_EN
    // 2*sum - LANES*len always lands inside the signed OUT_W range, so
    // modular arithmetic at OUT_W bits yields the exact two's complement value.
    assign w_sum_res = (OUT_W'(w_part[LANES]) << 1) - (OUT_W'(LANES) * OUT_W'(w_close_len));
`else
    assign w_sum_res = w_part[LANES];
`endif

    always_ff @(posedge i_clk_sn_acc or negedge i_rst_n_sn_acc) begin
        if (!i_rst_n_sn_acc) begin
            r_state   <= IDLE;
            r_len     <= '0;
            r_sum     <= '0;
            r_win_len <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
            for (int i = 0; i < LANES; i++) begin
                r_lane_cnt[i] <= '0;
            end
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_isgen) begin
                        r_state <= ACC;
                        r_len   <= CNT_W'(1);
                    end
                end
                ACC: begin
                    if (w_close) begin
                        r_state <= IDLE;
                        r_len   <= '0;
                    end else begin
                        r_len <= r_len + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_len   <= '0;
                end
            endcase

            // A close that finds the register occupied and unaccepted is lost.
            if (w_close) begin
                if (w_free) begin
                    r_sum     <= w_sum_res;
                    r_win_len <= w_close_len;
                    r_valid   <= 1'b1;
                    for (int i = 0; i < LANES; i++) begin
                        r_lane_cnt[i] <= w_close_cnt[i];
                    end
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_lane_cnt = r_lane_cnt;
    assign o_sum      = r_sum;
    assign o_win_len  = r_win_len;
    assign o_valid    = r_valid;
    assign o_overrun  = r_overrun;

endmodule

// File: tb/tb_sn_window_counter.sv
// Self-checking bench for sn_window_counter: directed scenarios plus random
// traffic compared every cycle against a window-level reference model.
module tb_sn_window_counter;
    import sn_window_counter_pkg::*;

    localparam int LANES   = DEF_LANES;
    localparam int WIN_LEN = DEF_WIN_LEN;
    localparam int CNT_W   = cnt_width(WIN_LEN);
    localparam int SUM_W   = sum_width(WIN_LEN, LANES);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic isgen = 1'b0;
    logic ready = 1'b0;
    logic sn_bit [LANES];
    logic w_bit  [LANES];
    logic [CNT_W-1:0] lane_cnt [LANES];
`ifdef SN_WINDOW_COUNTER_BIPOLAR_EN
    logic signed [SUM_W:0] sum;
`else
    logic [SUM_W-1:0] sum;
`endif
    logic [CNT_W-1:0] win_len;
    logic valid;
    logic overrun;

    int n_checks = 0;
    int n_errors = 0;
    int n_txn    = 0;

    // Reference model state: the open window and the output register contents.
    bit m_active;
    int m_acc [LANES];
    int m_len;
    int m_cnt [LANES];
    int m_wlen;
    int m_sum;
    bit m_valid;
    bit m_ovr;

    sn_window_counter dut (
        .i_clk_sn_acc   (clk),
        .i_rst_n_sn_acc (rst_n),
        .i_isgen        (isgen),
        .i_sn_bit       (sn_bit),
        .i_w_bit        (w_bit),
        .o_lane_cnt     (lane_cnt),
        .o_sum          (sum),
        .o_win_len      (win_len),
        .o_valid        (valid),
        .i_ready        (ready),
        .o_overrun      (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int prod(input logic s, input logic w);
`ifdef SN_WINDOW_COUNTER_BIPOLAR_EN
        return (s == w) ? 1 : 0;
`else
        return (s && w) ? 1 : 0;
`endif
    endfunction

    task automatic model_reset();
        m_active = 0;
        m_len    = 0;
        m_wlen   = 0;
        m_sum    = 0;
        m_valid  = 0;
        m_ovr    = 0;
        for (int i = 0; i < LANES; i++) begin
            m_acc[i] = 0;
            m_cnt[i] = 0;
        end
    endtask

    // One clock edge of the specification: extend or close the window, then
    // resolve the output register against the consumer handshake.
    task automatic model_edge(output bit loaded);
        bit close;
        bit free;
        int sigma;
        close  = 0;
        loaded = 0;
        free   = !m_valid || ready;
        if (isgen) begin
            if (!m_active) begin
                m_active = 1;
                m_len    = 0;
                for (int i = 0; i < LANES; i++) m_acc[i] = 0;
            end
            m_len++;
            for (int i = 0; i < LANES; i++) m_acc[i] += prod(sn_bit[i], w_bit[i]);
            if (m_len == WIN_LEN) close = 1;
        end else if (m_active) begin
            close = 1;
        end
        if (close) begin
            m_active = 0;
            if (free) begin
                sigma = 0;
                for (int i = 0; i < LANES; i++) begin
                    m_cnt[i] = m_acc[i];
                    sigma   += m_acc[i];
                end
                m_wlen = m_len;
`ifdef SN_WINDOW_COUNTER_BIPOLAR_EN
                m_sum = 2 * sigma - LANES * m_len;
`else
                m_sum = sigma;
`endif
                m_valid = 1;
                loaded  = 1;
            end else begin
                m_ovr = 1;
            end
        end else if (m_valid && ready) begin
            m_valid = 0;
        end
    endtask

    task automatic compare_all();
        check("valid", 32'(valid), 32'(m_valid));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("win_len", 32'(win_len), m_wlen);
        check("sum", 32'(sum), m_sum);
        for (int i = 0; i < LANES; i++) check($sformatf("lane_cnt%0d", i), 32'(lane_cnt[i]), m_cnt[i]);
    endtask

    task automatic step();
        bit loaded;
        @(posedge clk);
        model_edge(loaded);
        #1;
        compare_all();
        if (loaded) begin
            n_txn++;
            $display("txn %0d: win_len=%0d sum=%0d lanes=%0d,%0d,%0d,%0d", n_txn, m_wlen, m_sum,
                     m_cnt[0], m_cnt[1], m_cnt[2], m_cnt[3]);
        end
    endtask

    task automatic set_all(input logic s, input logic w);
        for (int i = 0; i < LANES; i++) begin
            sn_bit[i] = s;
            w_bit[i]  = w;
        end
    endtask

    // n consecutive stream bits with constant data/weights on every lane.
    task automatic run_bits(input int n, input logic s, input logic w);
        set_all(s, w);
        isgen = 1'b1;
        for (int k = 0; k < n; k++) step();
    endtask

    initial begin
        int pat [LANES];
        pat = '{15, 8, 4, 1};
        set_all(1'b0, 1'b0);
        model_reset();

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 32'(valid), 0);
        check("rst_overrun", 32'(overrun), 0);
        check("rst_sum", 32'(sum), 0);
        check("rst_win_len", 32'(win_len), 0);
        compare_all();
        @(negedge clk);
        rst_n = 1'b1;
        ready = 1'b1;
        step();

        // Generator-style patterns with all weights 1
        isgen = 1'b1;
        for (int t = 0; t < WIN_LEN; t++) begin
            for (int i = 0; i < LANES; i++) begin
                sn_bit[i] = (t < pat[i]);
                w_bit[i]  = 1'b1;
            end
            step();
            if (t == WIN_LEN - 2) check("pat_valid_early", 32'(valid), 0);
        end
        check("pat_valid", 32'(valid), 1);
        check("pat_lane0", 32'(lane_cnt[0]), 15);
        check("pat_lane1", 32'(lane_cnt[1]), 8);
        check("pat_lane2", 32'(lane_cnt[2]), 4);
        check("pat_lane3", 32'(lane_cnt[3]), 1);
        check("pat_win_len", 32'(win_len), 16);
`ifdef SN_WINDOW_COUNTER_BIPOLAR_EN
        check("pat_sum", 32'(sum), -8);
`else
        check("pat_sum", 32'(sum), 28);
`endif
        isgen = 1'b0;
        step();
        check("pat_valid_drop", 32'(valid), 0);

        // Short window of 5 all-ones bits
        run_bits(5, 1'b1, 1'b1);
        isgen = 1'b0;
        check("short_valid_pre", 32'(valid), 0);
        step();
        check("short_valid", 32'(valid), 1);
        check("short_win_len", 32'(win_len), 5);
        check("short_lane3", 32'(lane_cnt[3]), 5);
        check("short_sum", 32'(sum), 20);
        step();

        // Weight lane 2 held at 0
        set_all(1'b1, 1'b1);
        w_bit[2] = 1'b0;
        isgen = 1'b1;
        for (int k = 0; k < WIN_LEN; k++) step();
        check("w2_lane2", 32'(lane_cnt[2]), 0);
        check("w2_lane1", 32'(lane_cnt[1]), 16);
`ifdef SN_WINDOW_COUNTER_BIPOLAR_EN
        check("w2_sum", 32'(sum), 32);
`else
        check("w2_sum", 32'(sum), 48);
`endif
        isgen = 1'b0;
        step();

        // Close and accept on the same cycle
        ready = 1'b0;
        run_bits(3, 1'b1, 1'b1);
        isgen = 1'b0;
        step();
        step();
        check("ca_first_held", 32'(win_len), 3);
        run_bits(6, 1'b1, 1'b1);
        isgen = 1'b0;
        ready = 1'b1;
        step();
        check("ca_valid", 32'(valid), 1);
        check("ca_win_len", 32'(win_len), 6);
        check("ca_sum", 32'(sum), 24);
        check("ca_overrun", 32'(overrun), 0);
        step();
        check("ca_valid_drop", 32'(valid), 0);

        // Two full windows with the consumer stalled
        ready = 1'b0;
        run_bits(WIN_LEN, 1'b1, 1'b1);
        isgen = 1'b0;
        step();
        check("ovr_first_sum", 32'(sum), 64);
        run_bits(WIN_LEN, 1'b1, 1'b1);
        check("ovr_flag", 32'(overrun), 1);
        check("ovr_held_sum", 32'(sum), 64);
        check("ovr_held_valid", 32'(valid), 1);
        isgen = 1'b0;
        ready = 1'b1;
        step();
        check("ovr_consumed", 32'(valid), 0);
        check("ovr_data_hold", 32'(sum), 64);
        step();

        // Asynchronous reset in the middle of a window
        run_bits(7, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        isgen = 1'b0;
        #1;
        model_reset();
        check("arst_valid", 32'(valid), 0);
        check("arst_overrun", 32'(overrun), 0);
        check("arst_sum", 32'(sum), 0);
        check("arst_win_len", 32'(win_len), 0);
        check("arst_lane0", 32'(lane_cnt[0]), 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        run_bits(WIN_LEN, 1'b1, 1'b1);
        check("arst_next_sum", 32'(sum), 64);
        check("arst_next_len", 32'(win_len), 16);
        isgen = 1'b0;
        step();

`ifdef SN_WINDOW_COUNTER_BIPOLAR_EN
        // Bipolar extremes
        run_bits(WIN_LEN, 1'b1, 1'b0);
        check("bip_neg_sum", 32'(sum), -64);
        isgen = 1'b0;
        step();
        isgen = 1'b1;
        for (int k = 0; k < WIN_LEN; k++) begin
            for (int i = 0; i < LANES; i++) begin
                sn_bit[i] = 1'($urandom);
                w_bit[i]  = sn_bit[i];
            end
            step();
        end
        check("bip_pos_sum", 32'(sum), 64);
        isgen = 1'b0;
        step();
`endif

        // Random traffic
        for (int c = 0; c < 800; c++) begin
            isgen = ($urandom_range(0, 4) != 0);
            ready = ($urandom_range(0, 2) != 0);
            for (int i = 0; i < LANES; i++) begin
                sn_bit[i] = 1'($urandom);
                w_bit[i]  = 1'($urandom);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
